// File: rtl/cache_control.sv
// Cache controller FSM: hit service, dirty-line writeback and line allocate.
// Define CACHE_CONTROL_PERF_CNT_EN to build the saturating hit/miss/writeback counters.
module cache_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             miss,
    input  logic             dirty,
    output logic             set_dirty,
    output logic             reset_dirty,
    output logic             set_valid,
    output logic             load_tag,
    output logic             set_lru,
    output logic             data_read,
    output logic             load_data,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    // state     | meaning
    // IDLE      | waiting for a CPU request
    // CHECK     | tag compare; serve a hit or pick the miss path
    // WRITEBACK | dirty victim line going out to physical memory
    // ALLOCATE  | new line coming in from physical memory
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mem_resp    = 1'b0;
        set_dirty   = 1'b0;
        reset_dirty = 1'b0;
        set_valid   = 1'b0;
        load_tag    = 1'b0;
        set_lru     = 1'b0;
        data_read   = 1'b1;
        load_data   = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    set_lru    = 1'b1;
                    set_dirty  = mem_write;
                    load_data  = mem_write;
                    state_next = IDLE;
                end else if (miss) begin
                    state_next = dirty ? WRITEBACK : ALLOCATE;
                end
                // neither hit nor miss: datapath status not settled, re-check
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data   = 1'b1;
                    load_tag    = 1'b1;
                    set_valid   = 1'b1;
                    reset_dirty = 1'b1;
                    state_next  = CHECK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_CONTROL_PERF_CNT_EN
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    assign hit_inc  = (state == CHECK) && req && hit;
    assign miss_inc = (state == CHECK) && req && !hit && miss;
    assign wb_inc   = (state == WRITEBACK) && pmem_resp;

    // counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
            if (wb_inc && (wb_count != '1)) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: transaction-level model of latency,
// physical-memory traffic, fills and saturating counters, plus reset/drop cases.
module tb_cache_control;

    localparam int CNT_W = 3;
    localparam int SAT   = 7;
`ifdef CACHE_CONTROL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0;
    logic mem_write = 1'b0;
    logic hit = 1'b0;
    logic miss = 1'b1;
    logic dirty = 1'b0;
    logic resp_auto = 1'b0;
    logic resp_force = 1'b0;
    logic pmem_resp;
    logic mem_resp, set_dirty, reset_dirty, set_valid, load_tag, set_lru;
    logic data_read, load_data, pmem_read, pmem_write;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    assign pmem_resp = resp_auto | resp_force;

    cache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .miss(miss), .dirty(dirty),
        .set_dirty(set_dirty), .reset_dirty(reset_dirty), .set_valid(set_valid),
        .load_tag(load_tag), .set_lru(set_lru), .data_read(data_read),
        .load_data(load_data), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int lat;
        int rd_cyc;
        int wr_cyc;
        int fills;
        int hc;
        int mc;
        int wc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_hits = 0, m_miss = 0, m_wb = 0;
    int   lat_r = 1, lat_w = 1;
    bit   line_hit = 1'b0, line_dirty = 1'b0;
    bit   resp_seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    // physical memory: answers after lat cycles of an active request
    int pcnt = 0;
    always @(negedge clk) begin
        resp_auto = 1'b0;
        if (rst && (pmem_read || pmem_write)) begin
            pcnt++;
            if (pcnt >= (pmem_write ? lat_w : lat_r)) begin
                resp_auto = 1'b1;
                pcnt = 0;
            end
        end else begin
            pcnt = 0;
        end
    end

    // datapath: a completed fill makes the addressed line present and clean
    always @(negedge clk) begin
        #1;
        if (load_tag) begin
            line_hit = 1'b1;
            line_dirty = 1'b0;
        end
        hit = line_hit;
        miss = !line_hit;
        dirty = line_dirty;
    end

    task automatic set_line(input bit h, input bit d);
        line_hit = h;
        line_dirty = d;
        hit = h;
        miss = !h;
        dirty = d;
    endtask

    // monitor
    int   cyc = 0, rd_cyc = 0, wr_cyc = 0, fills = 0;
    bit   pend = 1'b0;
    exp_t pexp;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            cyc = 0; rd_cyc = 0; wr_cyc = 0; fills = 0; pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hit_count", int'(hit_count), pexp.hc);
                chk("miss_count", int'(miss_count), pexp.mc);
                chk("wb_count", int'(wb_count), pexp.wc);
                pend = 1'b0;
            end
            if (pmem_read || pmem_write)
                chk("pmem_rd_wr_overlap", int'(pmem_read & pmem_write), 0);
            if (pmem_read) rd_cyc++;
            if (pmem_write) wr_cyc++;
            if (load_tag || set_valid || reset_dirty) begin
                fills++;
                chk("fill_bundle", int'({load_tag, set_valid, reset_dirty, load_data, pmem_resp, pmem_read}), 63);
            end
            if (mem_read || mem_write) cyc++;
            if (mem_resp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_mem_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.lat);
                    chk("set_lru", int'(set_lru), 1);
                    chk("set_dirty", int'(set_dirty), int'(e.wr));
                    chk("load_data", int'(load_data), int'(e.wr));
                    chk("data_read", int'(data_read), 1);
                    chk("pmem_read_cycles", rd_cyc, e.rd_cyc);
                    chk("pmem_write_cycles", wr_cyc, e.wr_cyc);
                    chk("fills", fills, e.fills);
                    pexp = e;
                    pend = 1'b1;
                end
                resp_seen = 1'b1;
                cyc = 0; rd_cyc = 0; wr_cyc = 0; fills = 0;
            end
        end
    end

    // kind: 0 read, 1 write, 2 read+write; scen: 0 hit, 1 clean miss, 2 dirty miss
    task automatic do_req(input int kind, input int scen, input int lr, input int lw);
        exp_t e;
        bit ok;
        lat_r = lr;
        lat_w = lw;
        set_line(scen == 0, scen == 2);
        m_hits++;
        if (scen != 0) m_miss++;
        if (scen == 2) m_wb++;
        e.wr     = (kind != 0);
        e.lat    = (scen == 0) ? 1 : (scen == 1) ? lr + 2 : lr + lw + 2;
        e.rd_cyc = (scen == 0) ? 0 : lr;
        e.wr_cyc = (scen == 2) ? lw : 0;
        e.fills  = (scen == 0) ? 0 : 1;
        e.hc     = PERF ? sat(m_hits) : 0;
        e.mc     = PERF ? sat(m_miss) : 0;
        e.wc     = PERF ? sat(m_wb) : 0;
        sb.push_back(e);
        resp_seen = 1'b0;
        mem_read  = (kind != 1);
        mem_write = (kind != 0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #4;
            if (resp_seen) begin
                ok = 1'b1;
                break;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        resp_seen = 1'b0;
        chk("req_completed", int'(ok), 1);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
        #4;
    endtask

    task automatic drop_test();
        set_line(1'b1, 1'b0);
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        #3;
        chk("drop_mem_resp", int'(mem_resp), 0);
        chk("drop_writes", int'({load_data, set_dirty, set_lru, load_tag}), 0);
        @(negedge clk);
        #3;
        chk("drop_idle", int'({mem_resp, pmem_read, pmem_write}), 0);
        #1;
    endtask

    task automatic reset_test();
        lat_r = 20;
        set_line(1'b0, 1'b0);
        mem_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #4;
            if (pmem_read) break;
        end
        chk("alloc_entered", int'(pmem_read), 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;
        m_hits = 0; m_miss = 0; m_wb = 0;
        #1;
        chk("rst_pmem", int'({pmem_read, pmem_write}), 0);
        chk("rst_data_read", int'(data_read), 1);
        chk("rst_ctrl", int'({mem_resp, load_tag, load_data, set_valid, reset_dirty, set_dirty, set_lru}), 0);
        chk("rst_counters", int'({hit_count, miss_count, wb_count}), 0);
        @(negedge clk);
        #1;
        resp_force = 1'b1;
        #1;
        chk("late_resp_in_rst", int'({load_tag, load_data, set_valid}), 0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("late_resp_idle", int'({load_tag, load_data, set_valid, reset_dirty, pmem_read, mem_resp}), 0);
        resp_force = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_late", int'({pmem_read, pmem_write, mem_resp}), 0);
        rst = 1'b0;
        #3;
        rst = 1'b1;
        do_req(0, 0, 1, 1);
        gap(1);
        do_req(0, 1, 2, 1);
        gap(1);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("reset_ctrl", int'({mem_resp, pmem_read, pmem_write, load_tag, load_data, set_lru}), 0);
        chk("reset_data_read", int'(data_read), 1);
        chk("reset_counters", int'({hit_count, miss_count, wb_count}), 0);
        #3;
        rst = 1'b1;
        do_req(0, 0, 1, 1);
        gap(1);
        do_req(1, 0, 1, 1);
        gap(1);
        do_req(0, 1, 4, 1);
        gap(1);
        do_req(0, 2, 3, 2);
        gap(1);
        do_req(2, 2, 1, 1);
        gap(2);
        for (int i = 0; i < 40; i++) begin
            do_req(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
            gap(int'($urandom_range(1, 3)));
        end
        drop_test();
        gap(1);
        reset_test();
        for (int i = 0; i < 15; i++) begin
            do_req(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            gap(int'($urandom_range(1, 2)));
        end
        gap(2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, performance counter width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports mem_read, mem_write  input  1 each  CPU-side request, held by requester until mem_resp.
REQ-005 SHALL have port mem_resp  output  1  one-cycle completion pulse to requester.
REQ-006 SHALL have ports hit, miss, dirty  input  1 each  datapath status for addressed set / LRU way.
REQ-007 SHALL have ports set_dirty, reset_dirty, set_valid, load_tag, set_lru, data_read, load_data  output  1 each  datapath controls.
REQ-008 SHALL have port pmem_read  output  1  physical memory line-read request.
REQ-009 SHALL have port pmem_write  output  1  physical memory line-write request, also the datapath writeback-address select.
REQ-010 SHALL have port pmem_resp  input  1  physical memory completion, one cycle.
REQ-011 SHALL have ports hit_count, miss_count, wb_count  output  CNT_W each  performance counters.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, WRITEBACK, ALLOCATE; all outputs Moore/Mealy-decoded from state plus hit, dirty, mem_write, pmem_resp.
REQ-013 SHALL drive data_read=1 in every state; every other control output 0 unless stated below.
REQ-014 IDLE: mem_read|mem_write -> CHECK next cycle; else stay.
REQ-015 CHECK with hit: mem_resp=1, set_lru=1; if mem_write also set_dirty=1, load_data=1; -> IDLE.
REQ-016 CHECK with miss: dirty=1 -> WRITEBACK; dirty=0 -> ALLOCATE; mem_resp=0.
REQ-017 CHECK with no request asserted (request dropped) -> IDLE, no mem_resp, no array writes.
REQ-018 WRITEBACK: pmem_write=1 held until the cycle pmem_resp=1; then -> ALLOCATE.
REQ-019 ALLOCATE: pmem_read=1 held; in the cycle pmem_resp=1 also load_data=1, load_tag=1, set_valid=1, reset_dirty=1; then -> CHECK.
REQ-020 pmem_read and pmem_write SHALL never be asserted together.
REQ-021 pmem_resp in IDLE or CHECK SHALL be ignored.
REQ-022 mem_read and mem_write both high SHALL be treated as a write.
REQ-023 Hit latency: request sampled in IDLE at edge N, mem_resp asserted cycle N+1; clean miss completes in the second CHECK after fill.
REQ-024 hit_count SHALL increment once per CHECK cycle with hit and request; miss_count once per CHECK->WRITEBACK/ALLOCATE transition; wb_count once per WRITEBACK exit.
REQ-025 Counters SHALL saturate at 2**CNT_W-1, never wrap.
REQ-026 Hit in the post-fill CHECK SHALL count as a hit (a miss costs one miss plus one hit).

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, all control outputs 0 except data_read=1, counters 0, independent of clk.
REQ-028 Reset during WRITEBACK/ALLOCATE SHALL drop pmem_read/pmem_write in the same cycle; the pending pmem_resp is then ignored per REQ-021.
REQ-029 First request after rst deasserts SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro CACHE_CONTROL_PERF_CNT_EN defined: counters implemented per REQ-024..026.
REQ-031 Macro undefined: no counter flops; hit_count, miss_count, wb_count tied to 0; FSM behaviour identical.

Verification
REQ-032 Read hit: mem_read=1, hit=1 -> mem_resp=1 one cycle later, set_lru=1, load_data=0, hit_count=1.
REQ-033 Write hit: mem_write=1, hit=1 -> same cycle set_dirty=1, load_data=1, mem_resp=1.
REQ-034 Clean read miss: hit=0, dirty=0, pmem_resp after 4 cycles -> pmem_read high 4 cycles, load_tag/set_valid/reset_dirty pulse with pmem_resp, CHECK, mem_resp; miss_count=1, hit_count=1.
REQ-035 Dirty miss: dirty=1 -> pmem_write until pmem_resp, then pmem_read, no overlap; wb_count=1.
REQ-036 rst=0 mid-ALLOCATE -> pmem_read=0 same cycle, state IDLE, counters 0; late pmem_resp causes no array write.
